// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared definitions for the ManyCycleCPU multi-cycle controller.
//   - FSM state encodings (exported on the State debug port)
//   - opcode constants, ALUOp / PCSrc / RegDst encodings
//   - small opcode classification helpers used by decode and next-state logic
package mc_ctrl_pkg;

  localparam int unsigned OPCODE_W = 6;

  typedef enum logic [2:0] {
    S_IF    = 3'b000,
    S_ID    = 3'b001,
    S_EXE_A = 3'b110,
    S_EXE_B = 3'b101,
    S_EXE_C = 3'b010,
    S_MEM   = 3'b011,
    S_WB_A  = 3'b111,
    S_WB_C  = 3'b100
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_ADD   = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_SUB   = 6'b000001;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_OR    = 6'b010000;
  localparam logic [OPCODE_W-1:0] OP_AND   = 6'b010001;
  localparam logic [OPCODE_W-1:0] OP_ORI   = 6'b010010;
  localparam logic [OPCODE_W-1:0] OP_SLL   = 6'b011000;
  localparam logic [OPCODE_W-1:0] OP_SLT   = 6'b100110;
  localparam logic [OPCODE_W-1:0] OP_SLTIU = 6'b100111;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b110000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b110001;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b110100;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b111000;
  localparam logic [OPCODE_W-1:0] OP_JR    = 6'b111001;
  localparam logic [OPCODE_W-1:0] OP_JAL   = 6'b111010;
  localparam logic [OPCODE_W-1:0] OP_HALT  = 6'b111111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_SLL  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_SLTU = 3'b101;
  localparam logic [2:0] ALU_SLT  = 3'b110;

  localparam logic [1:0] PC_NEXT   = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_REG    = 2'b10;
  localparam logic [1:0] PC_JUMP   = 2'b11;

  localparam logic [1:0] RD_RA = 2'b00;
  localparam logic [1:0] RD_RT = 2'b01;
  localparam logic [1:0] RD_RD = 2'b10;

  function automatic logic isLegalOp(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI, OP_SLL, OP_SLT,
      OP_SLTIU, OP_SW, OP_LW, OP_BEQ, OP_J, OP_JR, OP_JAL, OP_HALT:
        isLegalOp = 1'b1;
      default: isLegalOp = 1'b0;
    endcase
  endfunction

  // ALU-class instructions that take the extended immediate and write rt.
  function automatic logic isImmAlu(input logic [OPCODE_W-1:0] op);
    isImmAlu = (op == OP_ADDI) || (op == OP_ORI) || (op == OP_SLTIU);
  endfunction

  function automatic logic [2:0] aluOpFor(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_SUB:          aluOpFor = ALU_SUB;
      OP_OR, OP_ORI:   aluOpFor = ALU_OR;
      OP_AND:          aluOpFor = ALU_AND;
      OP_SLL:          aluOpFor = ALU_SLL;
      OP_SLT:          aluOpFor = ALU_SLT;
      OP_SLTIU:        aluOpFor = ALU_SLTU;
      default:         aluOpFor = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: purely combinational control decode for the multi-cycle CPU.
//   Inputs : state (current FSM state), opcode (IR[31:26]), zero (ALU Zero flag)
//   Outputs: every datapath enable/mux select; all default to 0 in every state.
// Macro MCFSM_ILLEGAL_TRAP_EN: when defined, undefined opcodes behave like halt
// (no PC update in ID); otherwise they retire as a NOP from ID.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_t                state,
  input  logic [OPCODE_W-1:0]   opcode,
  input  logic                  zero,
  output logic                  pcWre,
  output logic                  irWre,
  output logic                  insMemRW,
  output logic                  aluSrcA,
  output logic                  aluSrcB,
  output logic                  dbDataSrc,
  output logic                  regWre,
  output logic                  wrRegDSrc,
  output logic [1:0]            regDst,
  output logic                  extSel,
  output logic [1:0]            pcSrc,
  output logic [2:0]            aluOp,
  output logic                  memRd,
  output logic                  memWr
);

  always_comb begin
    pcWre     = 1'b0;
    irWre     = 1'b0;
    insMemRW  = 1'b0;
    aluSrcA   = 1'b0;
    aluSrcB   = 1'b0;
    dbDataSrc = 1'b0;
    regWre    = 1'b0;
    wrRegDSrc = 1'b0;
    regDst    = RD_RA;
    extSel    = 1'b0;
    pcSrc     = PC_NEXT;
    aluOp     = ALU_ADD;
    memRd     = 1'b0;
    memWr     = 1'b0;

    case (state)
      S_IF: begin
        insMemRW = 1'b1;
        irWre    = 1'b1;
      end
      S_ID: begin
        case (opcode)
          OP_J: begin
            pcWre = 1'b1;
            pcSrc = PC_JUMP;
          end
          OP_JR: begin
            pcWre = 1'b1;
            pcSrc = PC_REG;
          end
          OP_JAL: begin
            pcWre  = 1'b1;
            pcSrc  = PC_JUMP;
            regWre = 1'b1;
            regDst = RD_RA;
          end
          default: begin
            if (!isLegalOp(opcode)) begin
`ifdef MCFSM_ILLEGAL_TRAP_EN
              pcWre = 1'b0;
`else
              pcWre = 1'b1;
              pcSrc = PC_NEXT;
`endif
            end
          end
        endcase
      end
      S_EXE_A: begin
        aluOp   = aluOpFor(opcode);
        aluSrcA = (opcode == OP_SLL);
        aluSrcB = isImmAlu(opcode);
        extSel  = (opcode == OP_ADDI) || (opcode == OP_SLTIU);
      end
      S_WB_A: begin
        regWre    = 1'b1;
        wrRegDSrc = 1'b1;
        regDst    = isImmAlu(opcode) ? RD_RT : RD_RD;
        pcWre     = 1'b1;
      end
      S_EXE_B: begin
        aluOp  = ALU_SUB;
        extSel = 1'b1;
        pcWre  = 1'b1;
        pcSrc  = zero ? PC_BRANCH : PC_NEXT;
      end
      S_EXE_C: begin
        aluOp   = ALU_ADD;
        aluSrcB = 1'b1;
        extSel  = 1'b1;
      end
      S_MEM: begin
        if (opcode == OP_SW) begin
          memWr = 1'b1;
          pcWre = 1'b1;
        end else begin
          memRd = 1'b1;
        end
      end
      S_WB_C: begin
        memRd     = 1'b1;
        dbDataSrc = 1'b1;
        regWre    = 1'b1;
        regDst    = RD_RT;
        wrRegDSrc = 1'b1;
        pcWre     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle control unit for the ManyCycleCPU datapath.
//   CLK, Reset (async, active-high), opcode (IR[31:26]), Zero (ALU flag)
//   State      : current FSM state for debug ports
//   PCWre ..mWR: datapath enables and mux selects (from mc_ctrl_decode)
//   halted     : sticky once halt is decoded, cleared only by Reset
// Holds the state register, halted flag and next-state logic; all control
// outputs are combinational from State/opcode/Zero.
// Macro MCFSM_ILLEGAL_TRAP_EN: undefined opcodes trap like halt when defined.
module mc_control_fsm
  import mc_ctrl_pkg::*;
(
  input  logic                CLK,
  input  logic                Reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                Zero,
  output logic [2:0]          State,
  output logic                PCWre,
  output logic                IRWre,
  output logic                InsMemRW,
  output logic                ALUSrcA,
  output logic                ALUSrcB,
  output logic                DBDataSrc,
  output logic                RegWre,
  output logic                WrRegDSrc,
  output logic [1:0]          RegDst,
  output logic                ExtSel,
  output logic [1:0]          PCSrc,
  output logic [2:0]          ALUOp,
  output logic                mRD,
  output logic                mWR,
  output logic                halted
);

  state_t state, stateNext;
  logic   haltedReg, haltNow;
  logic   pcWreRaw, irWreRaw, regWreRaw, memRdRaw, memWrRaw;

  mc_ctrl_decode uDecode (
    .state     (state),
    .opcode    (opcode),
    .zero      (Zero),
    .pcWre     (pcWreRaw),
    .irWre     (irWreRaw),
    .insMemRW  (InsMemRW),
    .aluSrcA   (ALUSrcA),
    .aluSrcB   (ALUSrcB),
    .dbDataSrc (DBDataSrc),
    .regWre    (regWreRaw),
    .wrRegDSrc (WrRegDSrc),
    .regDst    (RegDst),
    .extSel    (ExtSel),
    .pcSrc     (PCSrc),
    .aluOp     (ALUOp),
    .memRd     (memRdRaw),
    .memWr     (memWrRaw)
  );

  // Enables are killed for the whole Reset pulse, not just after the edge,
  // so nothing is written while the state register is being forced to IF.
  assign PCWre  = pcWreRaw  & ~Reset;
  assign IRWre  = irWreRaw  & ~Reset;
  assign RegWre = regWreRaw & ~Reset;
  assign mRD    = memRdRaw  & ~Reset;
  assign mWR    = memWrRaw  & ~Reset;

  assign State  = state;
  assign halted = haltedReg;

  always_comb begin
    haltNow = 1'b0;
    if (state == S_ID) begin
`ifdef MCFSM_ILLEGAL_TRAP_EN
      haltNow = (opcode == OP_HALT) || !isLegalOp(opcode);
`else
      haltNow = (opcode == OP_HALT);
`endif
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      S_IF: stateNext = S_ID;
      S_ID: begin
        if (haltedReg || haltNow) begin
          stateNext = S_ID;
        end else begin
          case (opcode)
            OP_J, OP_JR, OP_JAL: stateNext = S_IF;
            OP_BEQ:              stateNext = S_EXE_B;
            OP_SW, OP_LW:        stateNext = S_EXE_C;
            default:             stateNext = isLegalOp(opcode) ? S_EXE_A : S_IF;
          endcase
        end
      end
      S_EXE_A: stateNext = S_WB_A;
      S_WB_A:  stateNext = S_IF;
      S_EXE_B: stateNext = S_IF;
      S_EXE_C: stateNext = S_MEM;
      S_MEM:   stateNext = (opcode == OP_LW) ? S_WB_C : S_IF;
      S_WB_C:  stateNext = S_IF;
      default: stateNext = S_IF;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state     <= S_IF;
      haltedReg <= 1'b0;
    end else begin
      state     <= stateNext;
      haltedReg <= haltedReg | haltNow;
    end
  end

endmodule
